// File: rtl/axil_pkg.sv
// axil_pkg: shared FSM state type and AXI response codes for the AXI4-Lite master sequencer.
package axil_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axil_timeout_cnt.sv
// axil_timeout_cnt: response-wait watchdog; expired is high in the LIMIT-th consecutive enabled cycle.
module axil_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [15:0] cnt_q, cnt_d;
  assign expired = en && (cnt_q == 16'(LIMIT - 1));
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/axil_master_seq.sv
// axil_master_seq: single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Optional response timeout enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master_seq
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);
  state_e              state_q;
  logic                write_q, awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                rsp_valid_q, rsp_timeout_q;
  logic [1:0]          rsp_resp_q;
  logic [DATA_W-1:0]   rsp_rdata_q, wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done, w_done, rsp_hs, expired;
`ifdef AXIL_MASTER_TIMEOUT_EN
  axil_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == RESP),
    .clr     (state_q != RESP),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif
  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_write   = write_q;
  assign rsp_timeout = rsp_timeout_q;
  assign AWADDR      = addr_q;
  assign ARADDR      = addr_q;
  assign AWPROT      = 3'b000;
  assign ARPROT      = 3'b000;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign AWVALID     = awvalid_q;
  assign WVALID      = wvalid_q;
  assign ARVALID     = arvalid_q;
  assign BREADY      = bready_q;
  assign RREADY      = rready_q;
  // A channel counts as complete once accepted earlier or accepted this cycle.
  assign aw_done = !awvalid_q || AWREADY;
  assign w_done  = !wvalid_q || WREADY;
  assign rsp_hs  = write_q ? BVALID : RVALID;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          write_q       <= cmd_write;
          addr_q        <= cmd_addr;
          wdata_q       <= cmd_wdata;
          wstrb_q       <= cmd_wstrb;
          awvalid_q     <= cmd_write;
          wvalid_q      <= cmd_write;
          arvalid_q     <= !cmd_write;
          rsp_timeout_q <= 1'b0;
          state_q       <= ADDR;
        end
        ADDR: if (write_q) begin
          if (AWREADY) awvalid_q <= 1'b0;
          if (WREADY) wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end else if (ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RESP;
        end
        RESP: if (rsp_hs || expired) begin
          bready_q      <= 1'b0;
          rready_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_timeout_q <= !rsp_hs;
          rsp_resp_q    <= !rsp_hs ? RESP_SLVERR : write_q ? BRESP : RRESP;
          rsp_rdata_q   <= (!rsp_hs || write_q) ? '0 : RDATA;
          state_q       <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_master_seq.sv
// tb_axil_master_seq: directed scoreboard bench for axil_master_seq.
module tb_axil_master_seq;
  typedef struct packed {
    logic        w;
    logic [1:0]  r;
    logic [31:0] d;
    logic        t;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = '0;
  exp_t        sb[$];
  int          n_assert = 0, n_fail = 0;
  axil_master_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask
  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_write"}, rsp_write, e.w);
      chk({tag, "_resp"}, rsp_resp, e.r);
      chk({tag, "_rdata"}, rsp_rdata, e.d);
      chk({tag, "_timeout"}, rsp_timeout, e.t);
    end
  endtask
  task automatic check_rsp(input string tag);
    pop_cmp(tag);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk({tag, "_released"}, rsp_valid, 0);
  endtask
  task automatic chk_idle_bus(input string tag);
    chk({tag, "_awvalid"}, AWVALID, 0);
    chk({tag, "_wvalid"}, WVALID, 0);
    chk({tag, "_arvalid"}, ARVALID, 0);
    chk({tag, "_bready"}, BREADY, 0);
    chk({tag, "_rready"}, RREADY, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    step;
    step;
    chk_idle_bus("rst");
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_resp", rsp_resp, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    step;
    chk("idle_cmd_ready", cmd_ready, 1);
    // basic write, both channels ready, stray BVALID before RESP
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    sb.push_back('{w: 1'b1, r: 2'b00, d: 32'h0, t: 1'b0});
    step;
    cmd_valid = 1'b0;
    chk("wr_cmd_ready_addr", cmd_ready, 0);
    chk("wr_awvalid", AWVALID, 1);
    chk("wr_wvalid", WVALID, 1);
    chk("wr_awaddr", AWADDR, 32'h0000_0010);
    chk("wr_wdata", WDATA, 32'hDEAD_BEEF);
    chk("wr_wstrb", WSTRB, 4'hF);
    chk("wr_awprot", AWPROT, 3'b000);
    chk("wr_stray_bready", BREADY, 0);
    step;
    chk("wr_bready", BREADY, 1);
    chk("wr_lat2_rsp", rsp_valid, 0);
    step;
    check_rsp("wr1");
    // W accepted two cycles before AW
    AWREADY = 1'b0; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b10;
    send(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h3);
    sb.push_back('{w: 1'b1, r: 2'b10, d: 32'h0, t: 1'b0});
    step;
    cmd_valid = 1'b0;
    chk("split_c1_aw", AWVALID, 1);
    chk("split_c1_w", WVALID, 1);
    step;
    WREADY = 1'b0;
    chk("split_c2_w", WVALID, 0);
    chk("split_c2_aw", AWVALID, 1);
    chk("split_c2_bready", BREADY, 0);
    step;
    chk("split_c3_aw", AWVALID, 1);
    chk("split_c3_awaddr", AWADDR, 32'h0000_0044);
    chk("split_c3_w", WVALID, 0);
    AWREADY = 1'b1;
    step;
    AWREADY = 1'b0;
    chk("split_c4_aw", AWVALID, 0);
    chk("split_c4_bready", BREADY, 1);
    step;
    chk("split_c5_bready", BREADY, 1);
    chk("split_c5_rsp", rsp_valid, 0);
    BVALID = 1'b1;
    step;
    BVALID = 1'b0;
    chk("split_bready_drop", BREADY, 0);
    check_rsp("split");
    step;
    chk("split_single_rsp", rsp_valid, 0);
    chk("split_sb_empty", sb.size(), 0);
    // read with DECERR, stray RVALID before RESP
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b11;
    send(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    sb.push_back('{w: 1'b0, r: 2'b11, d: 32'h1234_5678, t: 1'b0});
    step;
    cmd_valid = 1'b0;
    chk("rd_arvalid", ARVALID, 1);
    chk("rd_araddr", ARADDR, 32'h0000_0020);
    chk("rd_arprot", ARPROT, 3'b000);
    chk("rd_awvalid", AWVALID, 0);
    chk("rd_stray_rready", RREADY, 0);
    step;
    chk("rd_arvalid_drop", ARVALID, 0);
    chk("rd_rready", RREADY, 1);
    step;
    check_rsp("rd");
    RVALID = 1'b0;
    // back-pressure on rsp_ready with a pending command
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hCAFE_0001; RRESP = 2'b00;
    send(1'b1, 32'h0000_0008, 32'h0000_0055, 4'hF);
    sb.push_back('{w: 1'b1, r: 2'b00, d: 32'h0, t: 1'b0});
    step;
    cmd_valid = 1'b0;
    step;
    step;
    send(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_write", rsp_write, 1);
      chk("bp_rsp_rdata", rsp_rdata, 0);
      chk("bp_rsp_resp", rsp_resp, 0);
      step;
    end
    pop_cmp("bp1");
    rsp_ready = 1'b1;
    sb.push_back('{w: 1'b0, r: 2'b00, d: 32'hCAFE_0001, t: 1'b0});
    step;
    rsp_ready = 1'b0;
    chk("bp_idle_cmd_ready", cmd_ready, 1);
    chk("bp_idle_rsp", rsp_valid, 0);
    step;
    cmd_valid = 1'b0;
    chk("bp2_arvalid", ARVALID, 1);
    chk("bp2_araddr", ARADDR, 32'h0000_0030);
    step;
    step;
    check_rsp("bp2");
    RVALID = 1'b0; BVALID = 1'b0;
    // reset pulse while waiting in RESP
    send(1'b1, 32'h0000_0050, 32'h1111_2222, 4'hF);
    step;
    cmd_valid = 1'b0;
    step;
    chk("mid_bready", BREADY, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    chk_idle_bus("mid_rst");
    chk("mid_cmd_ready", cmd_ready, 1);
    BVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_no_bready", BREADY, 0);
    end
    BVALID = 1'b0;
    // unanswered write: timeout when enabled, indefinite wait otherwise
    send(1'b1, 32'h0000_0060, 32'h3333_4444, 4'hF);
    step;
    cmd_valid = 1'b0;
    step;
`ifdef AXIL_MASTER_TIMEOUT_EN
    sb.push_back('{w: 1'b1, r: 2'b10, d: 32'h0, t: 1'b1});
    n = 0;
    for (int i = 0; i < 20 && BREADY; i++) begin
      n++;
      step;
    end
    chk("to_bready_cycles", n, 8);
    chk("to_bready_low", BREADY, 0);
    check_rsp("to");
`else
    sb.push_back('{w: 1'b1, r: 2'b01, d: 32'h0, t: 1'b0});
    for (int i = 0; i < 20; i++) step;
    chk("nto_bready", BREADY, 1);
    chk("nto_rsp", rsp_valid, 0);
    BVALID = 1'b1; BRESP = 2'b01;
    step;
    BVALID = 1'b0;
    check_rsp("nto");
`endif
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
